// File: rtl/orv64_fp_wb_arb.sv
// FP regfile write-port arbiter: MA-stage writeback has priority, FDIV/FSQRT results queue in a small FIFO.
// Writes reach the regfile one cycle after selection; ll_resp_ready drops only when the result FIFO is full.
module orv64_fp_wb_arb #(
    parameter int DATA_W    = 64,
    parameter int BUF_DEPTH = 2,
    parameter int N_REG     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_we,
    input  logic [$clog2(N_REG)-1:0]   pipe_addr,
    input  logic [DATA_W-1:0]          pipe_data,
    input  logic                       ll_issue_valid,
    input  logic [$clog2(N_REG)-1:0]   ll_issue_addr,
    input  logic                       ll_resp_valid,
    output logic                       ll_resp_ready,
    input  logic [$clog2(N_REG)-1:0]   ll_resp_addr,
    input  logic [DATA_W-1:0]          ll_resp_data,
    output logic                       rf_we,
    output logic [$clog2(N_REG)-1:0]   rf_wa,
    output logic [DATA_W-1:0]          rf_wd,
    output logic [N_REG-1:0]           busy_vec,
    output logic [$clog2(N_REG):0]     pend_cnt,
    output logic                       err_sticky
);
    localparam int AW   = $clog2(N_REG);
    localparam int PW   = $clog2(BUF_DEPTH);
    localparam int CW   = $clog2(BUF_DEPTH + 1);
    localparam int CNTW = AW + 1;

    logic [AW-1:0]     buf_addr [BUF_DEPTH];
    logic [DATA_W-1:0] buf_data [BUF_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     occ;

    logic              fifo_empty;
    logic              fifo_full;
    logic              xfer;
    logic              push;
    logic              pop;
    logic              sel_we;
    logic [AW-1:0]     sel_wa;
    logic [DATA_W-1:0] sel_wd;
    logic              clr;
    logic [AW-1:0]     clr_addr;
    logic [N_REG-1:0]  busy_nxt;
    logic [CNTW-1:0]   cnt_nxt;
    logic              err_issue;
    logic              err_resp;
    logic              err_pipe;

    assign fifo_empty    = (occ == '0);
    assign fifo_full     = (occ == CW'(BUF_DEPTH));
    assign ll_resp_ready = !fifo_full;
    assign xfer          = ll_resp_valid & ll_resp_ready;

    always_comb begin
        sel_we   = 1'b0;
        sel_wa   = pipe_addr;
        sel_wd   = pipe_data;
        push     = 1'b0;
        pop      = 1'b0;
        clr      = 1'b0;
        clr_addr = ll_resp_addr;
        if (pipe_we) begin
            sel_we = 1'b1;
            push   = xfer;
        end else if (!fifo_empty) begin
            sel_we   = 1'b1;
            sel_wa   = buf_addr[rd_ptr];
            sel_wd   = buf_data[rd_ptr];
            pop      = 1'b1;
            push     = xfer;
            clr      = 1'b1;
            clr_addr = buf_addr[rd_ptr];
        end else if (xfer) begin
            // Empty FIFO: bypass straight to the write port.
            sel_we = 1'b1;
            sel_wa = ll_resp_addr;
            sel_wd = ll_resp_data;
            clr    = 1'b1;
        end
    end

    // A new issue to the register being retired this cycle reuses it, so set beats clear.
    always_comb begin
        busy_nxt = busy_vec;
        if (clr)
            busy_nxt[clr_addr] = 1'b0;
        if (ll_issue_valid)
            busy_nxt[ll_issue_addr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < N_REG; i++)
            cnt_nxt = cnt_nxt + {{(CNTW-1){1'b0}}, busy_nxt[i]};
    end

    assign err_issue = ll_issue_valid & busy_vec[ll_issue_addr]
                     & !(clr && (clr_addr == ll_issue_addr));
    assign err_resp  = xfer & !busy_vec[ll_resp_addr];
    assign err_pipe  = pipe_we & busy_vec[pipe_addr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we      <= 1'b0;
            rf_wa      <= '0;
            rf_wd      <= '0;
            busy_vec   <= '0;
            pend_cnt   <= '0;
            err_sticky <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
        end else begin
            rf_we <= sel_we;
            if (sel_we) begin
                rf_wa <= sel_wa;
                rf_wd <= sel_wd;
            end
            busy_vec   <= busy_nxt;
            pend_cnt   <= cnt_nxt;
            err_sticky <= err_sticky | err_issue | err_resp | err_pipe;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= ll_resp_addr;
            buf_data[wr_ptr] <= ll_resp_data;
        end
    end

endmodule

// File: tb/tb_orv64_fp_wb_arb.sv
// Bench for orv64_fp_wb_arb: directed scenarios plus a randomized run against a queue-based reference model.
module tb_orv64_fp_wb_arb;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;
    localparam int N_REG  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              pipe_we = 1'b0;
    logic [4:0]        pipe_addr = '0;
    logic [DATA_W-1:0] pipe_data = '0;
    logic              ll_issue_valid = 1'b0;
    logic [4:0]        ll_issue_addr = '0;
    logic              ll_resp_valid = 1'b0;
    logic              ll_resp_ready;
    logic [4:0]        ll_resp_addr = '0;
    logic [DATA_W-1:0] ll_resp_data = '0;
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [N_REG-1:0]  busy_vec;
    logic [5:0]        pend_cnt;
    logic              err_sticky;

    always #5 clk = ~clk;

    orv64_fp_wb_arb #(.DATA_W(DATA_W), .BUF_DEPTH(DEPTH), .N_REG(N_REG)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .ll_issue_valid(ll_issue_valid), .ll_issue_addr(ll_issue_addr),
        .ll_resp_valid(ll_resp_valid), .ll_resp_ready(ll_resp_ready),
        .ll_resp_addr(ll_resp_addr), .ll_resp_data(ll_resp_data),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .busy_vec(busy_vec), .pend_cnt(pend_cnt), .err_sticky(err_sticky)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending results as a queue, outstanding registers as a bit set.
    typedef struct packed {
        logic [4:0]        addr;
        logic [DATA_W-1:0] data;
    } res_t;

    res_t              m_q[$];
    bit [N_REG-1:0]    m_busy;
    bit                m_err;
    bit                m_we;
    logic [4:0]        m_wa;
    logic [DATA_W-1:0] m_wd;
    bit                m_xfer;

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < N_REG; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic void model_step();
        res_t     e;
        bit       clr;
        bit [4:0] ca;
        if (!rst) begin
            m_q.delete();
            m_busy = '0; m_err = 0; m_we = 0; m_wa = '0; m_wd = '0; m_xfer = 0;
            return;
        end
        m_xfer = ll_resp_valid && (m_q.size() < DEPTH);
        clr = 0; ca = '0;
        e.addr = ll_resp_addr; e.data = ll_resp_data;
        if (m_xfer && !m_busy[ll_resp_addr]) m_err = 1;
        if (pipe_we && m_busy[pipe_addr]) m_err = 1;
        m_we = 1;
        if (pipe_we) begin
            m_wa = pipe_addr; m_wd = pipe_data;
            if (m_xfer) m_q.push_back(e);
        end else if (m_q.size() != 0) begin
            res_t h = m_q.pop_front();
            m_wa = h.addr; m_wd = h.data; clr = 1; ca = h.addr;
            if (m_xfer) m_q.push_back(e);
        end else if (m_xfer) begin
            m_wa = ll_resp_addr; m_wd = ll_resp_data; clr = 1; ca = ll_resp_addr;
        end else begin
            m_we = 0;
        end
        if (ll_issue_valid && m_busy[ll_issue_addr] && !(clr && ca == ll_issue_addr)) m_err = 1;
        if (clr) m_busy[ca] = 0;
        if (ll_issue_valid) m_busy[ll_issue_addr] = 1;
    endfunction

    function automatic logic [4:0] pick_reg(bit want_busy);
        logic [4:0] c[$];
        for (int i = 0; i < N_REG; i++) if (m_busy[i] == want_busy) c.push_back(5'(i));
        if (c.size() == 0) return 5'($urandom_range(0, 31));
        return c[$urandom_range(0, c.size() - 1)];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        pipe_we = 0; ll_issue_valid = 0; ll_resp_valid = 0;
    endtask

    task automatic test_reset();
        rst = 0; idle();
        tick(); tick();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
        vectors++; if (rf_wa !== 5'd0 || rf_wd !== 64'd0) begin miscompares++; $display("FAIL reset_rf_wa_wd got %0d/%h want 0/0", rf_wa, rf_wd); end
        vectors++; if (busy_vec !== 32'd0 || pend_cnt !== 6'd0) begin miscompares++; $display("FAIL reset_busy got %h/%0d want 0/0", busy_vec, pend_cnt); end
        vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL reset_err got %0b want 0", err_sticky); end
        rst = 1;
        tick();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL idle_rf_we got %0b want 0", rf_we); end
        vectors++; if (ll_resp_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready got %0b want 1", ll_resp_ready); end
    endtask

    task automatic test_pipe_write();
        pipe_we = 1; pipe_addr = 5'd3; pipe_data = 64'h4000_0000_0000_0000;
        tick();
        idle();
        vectors++; if (rf_we !== 1'b1 || rf_wa !== 5'd3) begin miscompares++; $display("FAIL pipe_wr got we=%0b wa=%0d want 1/3", rf_we, rf_wa); end
        vectors++; if (rf_wd !== 64'h4000_0000_0000_0000) begin miscompares++; $display("FAIL pipe_wd got %h want 4000000000000000", rf_wd); end
        vectors++; if (busy_vec !== 32'd0) begin miscompares++; $display("FAIL pipe_busy got %h want 0", busy_vec); end
        tick();
        vectors++; if (rf_we !== 1'b0 || rf_wd !== 64'h4000_0000_0000_0000) begin miscompares++; $display("FAIL pipe_hold got we=%0b wd=%h want 0/4000000000000000", rf_we, rf_wd); end
    endtask

    task automatic test_bypass();
        ll_issue_valid = 1; ll_issue_addr = 5'd7;
        tick();
        idle();
        vectors++; if (busy_vec !== 32'h80 || pend_cnt !== 6'd1) begin miscompares++; $display("FAIL byp_issue got %h/%0d want 80/1", busy_vec, pend_cnt); end
        repeat (4) tick();
        ll_resp_valid = 1; ll_resp_addr = 5'd7; ll_resp_data = 64'h3FF0_0000_0000_0000;
        vectors++; if (ll_resp_ready !== 1'b1) begin miscompares++; $display("FAIL byp_ready got %0b want 1", ll_resp_ready); end
        tick();
        idle();
        vectors++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 64'h3FF0_0000_0000_0000) begin miscompares++; $display("FAIL byp_write got %0b/%0d/%h want 1/7/3ff0000000000000", rf_we, rf_wa, rf_wd); end
        vectors++; if (busy_vec !== 32'd0 || pend_cnt !== 6'd0) begin miscompares++; $display("FAIL byp_clear got %h/%0d want 0/0", busy_vec, pend_cnt); end
        vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL byp_err got %0b want 0", err_sticky); end
    endtask

    task automatic test_fifo_order();
        logic [DATA_W-1:0] d1, d2, d4;
        d1 = 64'h1111_0000_0000_0001; d2 = 64'h2222_0000_0000_0002; d4 = 64'h4444_0000_0000_0004;
        ll_issue_valid = 1; ll_issue_addr = 5'd1; tick();
        ll_issue_addr = 5'd2; tick();
        ll_issue_addr = 5'd4; tick();
        idle();
        vectors++; if (pend_cnt !== 6'd3) begin miscompares++; $display("FAIL fifo_pend3 got %0d want 3", pend_cnt); end
        pipe_we = 1; pipe_addr = 5'd20; pipe_data = 64'hABCD;
        ll_resp_valid = 1; ll_resp_addr = 5'd1; ll_resp_data = d1; tick();
        ll_resp_addr = 5'd2; ll_resp_data = d2; tick();
        vectors++; if (ll_resp_ready !== 1'b0) begin miscompares++; $display("FAIL fifo_full_ready got %0b want 0", ll_resp_ready); end
        ll_resp_addr = 5'd4; ll_resp_data = d4; tick(); tick();
        vectors++; if (ll_resp_ready !== 1'b0 || rf_wa !== 5'd20 || pend_cnt !== 6'd3) begin miscompares++; $display("FAIL fifo_stall got rdy=%0b wa=%0d pend=%0d want 0/20/3", ll_resp_ready, rf_wa, pend_cnt); end
        pipe_we = 0; tick();
        vectors++; if (rf_we !== 1'b1 || rf_wa !== 5'd1 || rf_wd !== d1 || pend_cnt !== 6'd2) begin miscompares++; $display("FAIL fifo_pop1 got %0b/%0d/%h/%0d want 1/1/%h/2", rf_we, rf_wa, rf_wd, pend_cnt, d1); end
        tick();
        ll_resp_valid = 0;
        vectors++; if (rf_we !== 1'b1 || rf_wa !== 5'd2 || rf_wd !== d2 || pend_cnt !== 6'd1) begin miscompares++; $display("FAIL fifo_pop2 got %0b/%0d/%h/%0d want 1/2/%h/1", rf_we, rf_wa, rf_wd, pend_cnt, d2); end
        tick();
        vectors++; if (rf_we !== 1'b1 || rf_wa !== 5'd4 || rf_wd !== d4 || pend_cnt !== 6'd0) begin miscompares++; $display("FAIL fifo_pop4 got %0b/%0d/%h/%0d want 1/4/%h/0", rf_we, rf_wa, rf_wd, pend_cnt, d4); end
        vectors++; if (busy_vec !== 32'd0 || err_sticky !== 1'b0) begin miscompares++; $display("FAIL fifo_end got %h/%0b want 0/0", busy_vec, err_sticky); end
    endtask

    task automatic test_set_wins();
        ll_issue_valid = 1; ll_issue_addr = 5'd9; tick();
        idle(); tick();
        ll_issue_valid = 1; ll_issue_addr = 5'd9;
        ll_resp_valid = 1; ll_resp_addr = 5'd9; ll_resp_data = 64'h9999;
        tick();
        idle();
        vectors++; if (rf_we !== 1'b1 || rf_wa !== 5'd9) begin miscompares++; $display("FAIL setwin_write got %0b/%0d want 1/9", rf_we, rf_wa); end
        vectors++; if (busy_vec !== 32'h200 || pend_cnt !== 6'd1) begin miscompares++; $display("FAIL setwin_busy got %h/%0d want 200/1", busy_vec, pend_cnt); end
        vectors++; if (err_sticky !== 1'b0) begin miscompares++; $display("FAIL setwin_err got %0b want 0", err_sticky); end
        ll_resp_valid = 1; ll_resp_addr = 5'd9; ll_resp_data = 64'h9998; tick();
        idle();
        vectors++; if (busy_vec !== 32'd0) begin miscompares++; $display("FAIL setwin_clear got %h want 0", busy_vec); end
    endtask

    task automatic test_err_unbusy();
        ll_resp_valid = 1; ll_resp_addr = 5'd12; ll_resp_data = 64'hC0DE; tick();
        idle();
        vectors++; if (rf_we !== 1'b1 || rf_wa !== 5'd12 || rf_wd !== 64'hC0DE) begin miscompares++; $display("FAIL err_write got %0b/%0d/%h want 1/12/c0de", rf_we, rf_wa, rf_wd); end
        vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL err_set got %0b want 1", err_sticky); end
        repeat (3) tick();
        vectors++; if (err_sticky !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %0b want 1", err_sticky); end
        rst = 0; pipe_we = 1; pipe_addr = 5'd5; tick();
        rst = 1; idle();
        vectors++; if (err_sticky !== 1'b0 || rf_we !== 1'b0) begin miscompares++; $display("FAIL err_reset got err=%0b we=%0b want 0/0", err_sticky, rf_we); end
        tick();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL post_reset_we got %0b want 0", rf_we); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst            = ($urandom_range(0, 199) != 0);
            pipe_we        = ($urandom_range(0, 1) == 1);
            pipe_addr      = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : pick_reg(0);
            pipe_data      = {$urandom(), $urandom()};
            ll_issue_valid = ($urandom_range(0, 3) == 0);
            ll_issue_addr  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : pick_reg(0);
            if (!(ll_resp_valid && !m_xfer)) begin
                ll_resp_valid = ($urandom_range(0, 2) == 0);
                ll_resp_addr  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : pick_reg(1);
                ll_resp_data  = {$urandom(), $urandom()};
            end
            tick();
            vectors++; if (rf_we !== m_we) begin miscompares++; $display("FAIL rand_we cyc %0d got %0b want %0b", cyc, rf_we, m_we); end
            vectors++; if (rf_wa !== m_wa || rf_wd !== m_wd) begin miscompares++; $display("FAIL rand_wa_wd cyc %0d got %0d/%h want %0d/%h", cyc, rf_wa, rf_wd, m_wa, m_wd); end
            vectors++; if (busy_vec !== m_busy || pend_cnt !== 6'(busy_count())) begin miscompares++; $display("FAIL rand_busy cyc %0d got %h/%0d want %h/%0d", cyc, busy_vec, pend_cnt, m_busy, busy_count()); end
            vectors++; if (err_sticky !== m_err) begin miscompares++; $display("FAIL rand_err cyc %0d got %0b want %0b", cyc, err_sticky, m_err); end
            vectors++; if (ll_resp_ready !== (m_q.size() < DEPTH)) begin miscompares++; $display("FAIL rand_ready cyc %0d got %0b want %0b", cyc, ll_resp_ready, m_q.size() < DEPTH); end
        end
        idle(); rst = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_pipe_write();
        test_bypass();
        test_fifo_order();
        test_set_wins();
        test_err_unbusy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/orv64_fp_wb_arb.md
Name: orv64_fp_wb_arb

Overview:
- Write-side front end of the FP register file; owns its single write port.
- Merges two write sources:
  - the in-order MA-stage FP writeback, which has fixed priority and no backpressure;
  - results from the long-latency FP unit (FDIV/FSQRT), delivered over a valid/ready handshake and buffered in a small FIFO.
- Keeps a per-register pending scoreboard so ID can stall on RAW/WAW against outstanding long-latency results.

Parameters:
- DATA_W, 64, FP register data width.
- BUF_DEPTH, 2, long-latency result FIFO entries (power of 2, ≥2).
- N_REG, 32, number of FP registers; address width is log2(N_REG).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- pipe_we  in  1  MA-stage FP write enable.
- pipe_addr  in  5  MA-stage destination register.
- pipe_data  in  DATA_W  MA-stage write data.
- ll_issue_valid  in  1  long-latency op issued this cycle.
- ll_issue_addr  in  5  destination register of the issued op.
- ll_resp_valid  in  1  long-latency result valid.
- ll_resp_ready  out  1  arbiter can accept a result.
- ll_resp_addr  in  5  result destination register.
- ll_resp_data  in  DATA_W  result data.
- rf_we  out  1  register file write enable.
- rf_wa  out  5  register file write address.
- rf_wd  out  DATA_W  register file write data.
- busy_vec  out  N_REG  bit i set = long-latency write to f[i] outstanding.
- pend_cnt  out  log2(N_REG)+1  number of set busy_vec bits.
- err_sticky  out  1  protocol violation seen; cleared only by reset.

Behaviour:
- Reset (rst=0 at a clk edge): rf_we=0, rf_wa=0, rf_wd=0, busy_vec=0, pend_cnt=0, err_sticky=0, FIFO empty. ll_resp_ready=1 from the first cycle after reset.
- Handshake: a result transfers when ll_resp_valid & ll_resp_ready. ll_resp_ready = !fifo_full, a registered-state function with no combinational path from ll_resp_valid. Addr/data must stay stable while valid and not ready.
- Write select, evaluated each cycle in priority order:
  1. pipe_we=1 → write pipe_addr/pipe_data. An accepted result is pushed to the FIFO.
  2. Else if FIFO non-empty → pop the head and write it. A same-cycle accepted result is pushed.
  3. Else if a result transfers → write it directly; FIFO is not touched (bypass).
  4. Else no write.
- Output timing: rf_we/rf_wa/rf_wd are registered, so the write reaches the regfile on the edge after selection.
  - Pipe-to-rf latency is 1 cycle.
  - Bypassed result latency is 1 cycle.
  - Buffered result latency is 1 cycle after it becomes head with pipe_we=0.
- rf_wd holds its last value when rf_we=0.
- FIFO:
  - Circular buffer with wrapping read/write pointers plus an occupancy counter.
  - Push and pop in the same cycle when full is legal only if the pop occurs. ready is computed before the pop, so a full FIFO never accepts.
  - Results are written in acceptance order.
- Scoreboard:
  - ll_issue_valid sets busy_vec[ll_issue_addr].
  - A bit clears on the cycle its long-latency result is selected for writing, whether popped or bypassed.
  - Set and clear of the same bit in one cycle: set wins, because the new issue reuses the register.
  - pipe_we never changes busy_vec.
  - pend_cnt is the registered popcount of busy_vec; it updates with busy_vec.
- Errors (sticky):
  - issue to an already-busy register, except in the same-cycle-clear case above;
  - a result transfer whose addr bit is not busy;
  - pipe_we to a busy register (WAW that ID failed to stall).
  - Writes are still performed normally on every error.
- Reset mid-operation: FIFO contents and the scoreboard are discarded. No rf_we is issued in the cycle after reset.
- Throughput: at most one rf write per cycle. Sustained pipe_we starves the FIFO; ready deasserts when it is full.

Test Plan:
- Reset then idle → rf_we=0, busy_vec=0, pend_cnt=0, ll_resp_ready=1.
- pipe_we=1, addr=3, data=0x4000_0000_0000_0000 → next cycle rf_we=1, rf_wa=3, rf_wd=0x4000_0000_0000_0000; busy_vec stays 0.
- Issue to addr=7; 5 cycles later result addr=7, data=0x3FF0_0000_0000_0000, pipe idle → bypass: rf write to f7 next cycle; busy_vec[7] 1→0; pend_cnt 1→0; err_sticky=0.
- Issue to f1, f2, f4. Hold pipe_we=1 while results f1, f2 are accepted → FIFO full, ready=0, the f4 result is stalled. Drop pipe_we → writes f1, f2, f4 on consecutive cycles, in that order; pend_cnt 3→0.
- Issue to f9 and, in the same cycle, result f9 bypassed → busy_vec[9]=1 remains (set wins); err_sticky=0.
- Result for f12 with busy_vec[12]=0 → write still occurs; err_sticky=1 until rst=0.
